// File: rtl/sparc_fetch_stage_if.sv
// sparc_fetch_stage_if: fetch-stage control inputs, instr-mem port and IF/ID outputs
interface sparc_fetch_stage_if;
  logic        stall_if;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        annul_ds;
  logic [31:0] instr_in;
  logic [31:0] pc_if;
  logic [31:0] npc_if;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic [31:0] npc_id;
  logic        valid_id;
  logic [31:0] fetch_count;
  modport master (
    output stall_if, branch_taken, branch_target, annul_ds, instr_in,
    input  pc_if, npc_if, instr_id, pc_id, npc_id, valid_id, fetch_count
  );
  modport slave (
    input  stall_if, branch_taken, branch_target, annul_ds, instr_in,
    output pc_if, npc_if, instr_id, pc_id, npc_id, valid_id, fetch_count
  );
endinterface

// File: rtl/sparc_fetch_stage.sv
// sparc_fetch_stage: SPARC PC/nPC fetch with delay-slot redirect, annul, stall and IF/ID register
module sparc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] RESET_NPC = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h01000000
) (
  input logic clk,
  input logic reset,
  sparc_fetch_stage_if.slave bus
);
  typedef enum logic {RST, RUN} state_t;
  state_t      state;
  logic [31:0] pc, npc, instr_q, pc_q, npc_q, cnt, nxt;
  logic        valid_q;
  assign nxt = bus.branch_taken ? {bus.branch_target[31:2], 2'b00} : npc;
  always_ff @(posedge clk)
    if (!reset) begin
      state   <= RST;
      pc      <= RESET_PC;
      npc     <= RESET_NPC;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
      cnt     <= '0;
    end else if (!bus.stall_if) begin
      state   <= RUN;
      pc      <= nxt;
      npc     <= nxt + 32'd4;
      instr_q <= bus.annul_ds ? NOP_INSTR : bus.instr_in;
      pc_q    <= pc;
      npc_q   <= npc;
      valid_q <= !bus.annul_ds;
      cnt     <= bus.annul_ds ? cnt : cnt + 32'd1;
    end
  // nothing live can sit in IF/ID until the first non-stalled edge after reset
  always_comb if (reset) assert (state == RUN || !valid_q);
  assign bus.pc_if       = pc;
  assign bus.npc_if      = npc;
  assign bus.instr_id    = instr_q;
  assign bus.pc_id       = pc_q;
  assign bus.npc_id      = npc_q;
  assign bus.valid_id    = valid_q;
  assign bus.fetch_count = cnt;
endmodule

// File: tb/tb_sparc_fetch_stage.sv
// tb_sparc_fetch_stage: directed vector table, corner sequences and randomized run vs. a reference model
module tb_sparc_fetch_stage;
  localparam logic [31:0] NOP = 32'h01000000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  sparc_fetch_stage_if bif();
  sparc_fetch_stage dut (.clk(clk), .reset(reset), .bus(bif));
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h13579BDF;
  endfunction
  assign bif.instr_in = mem(bif.pc_if);

  logic [31:0] m_pc, m_npc, m_instr, m_pcid, m_npcid, m_cnt;
  logic        m_v;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_edge(input logic rn, input logic st, input logic br, input logic [31:0] tgt, input logic an);
    logic [31:0] nx;
    if (!rn) begin
      m_pc = 32'd0; m_npc = 32'd4; m_instr = NOP; m_pcid = 0; m_npcid = 0; m_v = 0; m_cnt = 0;
    end else if (!st) begin
      m_instr = an ? NOP : mem(m_pc);
      m_v     = !an;
      m_pcid  = m_pc;
      m_npcid = m_npc;
      m_cnt   = an ? m_cnt : m_cnt + 1;
      nx      = br ? {tgt[31:2], 2'b00} : m_npc;
      m_pc    = nx;
      m_npc   = nx + 32'd4;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc_if"}, bif.pc_if, m_pc);
    chk({tag, ".npc_if"}, bif.npc_if, m_npc);
    chk({tag, ".instr_id"}, bif.instr_id, m_instr);
    chk({tag, ".pc_id"}, bif.pc_id, m_pcid);
    chk({tag, ".npc_id"}, bif.npc_id, m_npcid);
    chk({tag, ".valid_id"}, {31'd0, bif.valid_id}, {31'd0, m_v});
    chk({tag, ".fetch_count"}, bif.fetch_count, m_cnt);
  endtask

  task automatic step(input logic rn, input logic st, input logic br, input logic [31:0] tgt, input logic an);
    reset = rn; bif.stall_if = st; bif.branch_taken = br; bif.branch_target = tgt; bif.annul_ds = an;
    @(posedge clk);
    model_edge(rn, st, br, tgt, an);
    @(negedge clk);
  endtask

  typedef struct {
    logic st, br, an;
    logic [31:0] tgt, pc, npc, pcid;
    logic v;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 0, 32'd0,   32'd4,    32'd8,    32'd0,  1, 32'd1};
    tbl[1] = '{0, 0, 0, 32'd0,   32'd8,    32'd12,   32'd4,  1, 32'd2};
    tbl[2] = '{1, 0, 0, 32'd0,   32'd8,    32'd12,   32'd4,  1, 32'd2};
    tbl[3] = '{1, 1, 1, 32'd100, 32'd8,    32'd12,   32'd4,  1, 32'd2};
    tbl[4] = '{0, 0, 0, 32'd0,   32'd12,   32'd16,   32'd8,  1, 32'd3};
    tbl[5] = '{0, 0, 0, 32'd0,   32'd16,   32'd20,   32'd12, 1, 32'd4};
    tbl[6] = '{0, 1, 0, 32'd40,  32'd40,   32'd44,   32'd16, 1, 32'd5};
    tbl[7] = '{0, 0, 0, 32'd0,   32'd44,   32'd48,   32'd40, 1, 32'd6};
    tbl[8] = '{0, 1, 1, 32'h2B,  32'h28,   32'h2C,   32'd44, 0, 32'd6};
    tbl[9] = '{0, 0, 0, 32'd0,   32'h2C,   32'h30,   32'h28, 1, 32'd7};
    bif.stall_if = 0; bif.branch_taken = 0; bif.branch_target = 0; bif.annul_ds = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst.pc_if", bif.pc_if, 32'd0);
    chk("rst.npc_if", bif.npc_if, 32'd4);
    chk("rst.instr_id", bif.instr_id, NOP);
    chk("rst.valid_id", {31'd0, bif.valid_id}, 32'd0);
    chk("rst.fetch_count", bif.fetch_count, 32'd0);
    chk_model("rst");
    for (int i = 0; i < 10; i++) begin
      step(1, tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].an);
      chk($sformatf("vec%0d.pc_if", i), bif.pc_if, tbl[i].pc);
      chk($sformatf("vec%0d.npc_if", i), bif.npc_if, tbl[i].npc);
      chk($sformatf("vec%0d.pc_id", i), bif.pc_id, tbl[i].pcid);
      chk($sformatf("vec%0d.npc_id", i), bif.npc_id, tbl[i].pcid + 32'd4);
      chk($sformatf("vec%0d.valid_id", i), {31'd0, bif.valid_id}, {31'd0, tbl[i].v});
      chk($sformatf("vec%0d.instr_id", i), bif.instr_id, tbl[i].v ? mem(tbl[i].pcid) : NOP);
      chk($sformatf("vec%0d.fetch_count", i), bif.fetch_count, tbl[i].cnt);
    end
    step(1, 0, 1, 32'hFFFFFFF8, 0);
    step(1, 0, 0, 0, 0);
    chk("wrap.pc_if", bif.pc_if, 32'hFFFFFFFC);
    chk("wrap.npc_if", bif.npc_if, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("wrap2.pc_if", bif.pc_if, 32'd0);
    chk("wrap2.npc_if", bif.npc_if, 32'd4);
    force dut.cnt = 32'hFFFFFFFF;
    #1 release dut.cnt;
    m_cnt = 32'hFFFFFFFF;
    step(1, 0, 0, 0, 0);
    chk("cnt_wrap", bif.fetch_count, 32'd0);
    chk_model("cnt_wrap");
    step(0, 1, 1, 32'h80, 1);
    chk("rst_mid.pc_if", bif.pc_if, 32'd0);
    chk("rst_mid.valid_id", {31'd0, bif.valid_id}, 32'd0);
    chk_model("rst_mid");
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) >= 4, $urandom_range(99) < 25, $urandom_range(99) < 20,
           $urandom, $urandom_range(99) < 15);
      chk_model($sformatf("rnd%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
